// File: rtl/kpn_pkg.sv
// rtl/kpn_pkg.sv - shared token type and channel-state definitions for KPN process modules
package kpn_pkg;

  localparam int TOKEN_WIDTH = 16;

  typedef logic [TOKEN_WIDTH-1:0] token_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } chan_state_e;

  function automatic chan_state_e chan_state(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0) begin
      return EMPTY;
    end else if (cnt >= depth) begin
      return FULL;
    end else begin
      return PARTIAL;
    end
  endfunction

endpackage

// File: rtl/kpn_fifo_mem.sv
// rtl/kpn_fifo_mem.sv - token register array with one write port and a registered read port
module kpn_fifo_mem #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 8,
  parameter int INIT_TOKENS = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
    // Read sees the pre-write contents, so a same-slot read/write when full returns the oldest token.
    rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i < INIT_TOKENS) begin
          mem_q[i] <= '0;
        end
      end
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/kpn_fifo_channel.sv
// rtl/kpn_fifo_channel.sv - bounded KPN FIFO channel with preloaded delay tokens and sticky error flags
module kpn_fifo_channel
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 8,
  parameter int INIT_TOKENS = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr,
  input  logic [DATA_WIDTH-1:0]      entry_1,
  input  logic                       rd,
  output logic [DATA_WIDTH-1:0]      output_1,
  output logic                       valid_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] INIT_PTR = PTR_W'(INIT_TOKENS % DEPTH);
  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_TOKENS);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  chan_state_e      state;

  assign state = chan_state(32'(count_q), DEPTH);
  assign full  = (state == FULL);
  assign empty = (state == EMPTY);

  always_comb begin
    rd_acc = rd & ~empty;
    // A full channel still accepts a write when a read frees a slot in the same cycle.
    wr_acc = wr & (~full | rd_acc);

    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    valid_d     = rd_acc;
    overflow_d  = overflow_q | (wr & ~wr_acc);
    underflow_d = underflow_q | (rd & ~rd_acc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= INIT_PTR;
      rd_ptr_q    <= '0;
      count_q     <= INIT_CNT;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  kpn_fifo_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .INIT_TOKENS (INIT_TOKENS)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (entry_1),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (output_1)
  );

  assign count     = count_q;
  assign valid_out = valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// tb/tb_kpn_fifo_channel.sv - directed self-checking bench for kpn_fifo_channel
module tb_kpn_fifo_channel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr, rd;
  logic [15:0] entry_1;

  logic [15:0] out_a, out_b, out_c;
  logic        valid_a, valid_b, valid_c;
  logic        full_a, full_b, full_c;
  logic        empty_a, empty_b, empty_c;
  logic [3:0]  cnt_a, cnt_b, cnt_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        udf_a, udf_b, udf_c;

  kpn_fifo_channel #(.DATA_WIDTH(16), .DEPTH(8), .INIT_TOKENS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr(wr), .entry_1(entry_1), .rd(rd),
    .output_1(out_a), .valid_out(valid_a), .full(full_a), .empty(empty_a),
    .count(cnt_a), .overflow(ovf_a), .underflow(udf_a)
  );

  kpn_fifo_channel #(.DATA_WIDTH(16), .DEPTH(8), .INIT_TOKENS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr(wr), .entry_1(entry_1), .rd(rd),
    .output_1(out_b), .valid_out(valid_b), .full(full_b), .empty(empty_b),
    .count(cnt_b), .overflow(ovf_b), .underflow(udf_b)
  );

  kpn_fifo_channel #(.DATA_WIDTH(16), .DEPTH(8), .INIT_TOKENS(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr(wr), .entry_1(entry_1), .rd(rd),
    .output_1(out_c), .valid_out(valid_c), .full(full_c), .empty(empty_c),
    .count(cnt_c), .overflow(ovf_c), .underflow(udf_c)
  );

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [15:0] e_out;
    logic        e_valid;
    logic [3:0]  e_cnt;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
    logic        e_udf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic r, input logic w, input logic rdv, input logic [15:0] din,
                              input logic [15:0] eo, input logic ev, input int ec,
                              input logic ef, input logic ee, input logic eov, input logic eud);
    vec_t v;
    v.rst_n = r; v.wr = w; v.rd = rdv; v.din = din;
    v.e_out = eo; v.e_valid = ev; v.e_cnt = 4'(ec);
    v.e_full = ef; v.e_empty = ee; v.e_ovf = eov; v.e_udf = eud;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic rdv, input logic [15:0] d);
    @(negedge clk);
    rst_n = r; wr = w; rd = rdv; entry_1 = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack_a();
    return {7'd0, out_a, valid_a, cnt_a, full_a, empty_a, ovf_a, udf_a};
  endfunction

  function automatic logic [15:0] tok(input int k);
    return 16'(32'hC000 + k * 7);
  endfunction

  initial begin
    vec_t v;
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; entry_1 = '0;

    // basic write/read of three tokens
    add(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 16'h0001, 16'h0000, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 16'h0002, 16'h0000, 0, 2, 0, 0, 0, 0);
    add(1, 1, 0, 16'h0003, 16'h0000, 0, 3, 0, 0, 0, 0);
    add(1, 0, 1, 16'h0000, 16'h0001, 1, 2, 0, 0, 0, 0);
    add(1, 0, 1, 16'h0000, 16'h0002, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 16'h0000, 16'h0003, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 16'h0000, 16'h0003, 0, 0, 0, 1, 0, 0);
    // fill, overflow, simultaneous rd/wr when full, then drain
    for (int i = 0; i < 8; i++) begin
      add(1, 1, 0, 16'(16'h0010 + i), 16'h0003, 0, i + 1, (i == 7), 0, 0, 0);
    end
    add(1, 1, 0, 16'h0099, 16'h0003, 0, 8, 1, 0, 1, 0);
    add(1, 1, 1, 16'h5555, 16'h0010, 1, 8, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      add(1, 0, 1, 16'h0000, (i < 7) ? 16'(16'h0011 + i) : 16'h5555, 1, 7 - i, 0, (i == 7), 1, 0);
    end
    // underflow, then rd&wr on empty (no bypass)
    add(1, 0, 1, 16'h0000, 16'h5555, 0, 0, 0, 1, 1, 1);
    add(1, 1, 1, 16'h1234, 16'h5555, 0, 1, 0, 0, 1, 1);
    add(1, 0, 1, 16'h0000, 16'h1234, 1, 0, 0, 1, 1, 1);
    // reset with strobes in flight
    add(0, 1, 1, 16'hFFFF, 16'h0000, 0, 0, 0, 1, 0, 0);

    drive(0, 0, 0, 16'h0000);
    chk("rst_b_count", 32'(cnt_b), 32'd2);
    chk("rst_b_empty", 32'(empty_b), 32'd0);
    chk("rst_c_count", 32'(cnt_c), 32'd8);
    chk("rst_c_full", 32'(full_c), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst_n, v.wr, v.rd, v.din);
      chk($sformatf("vec%0d", i), pack_a(),
          {7'd0, v.e_out, v.e_valid, v.e_cnt, v.e_full, v.e_empty, v.e_ovf, v.e_udf});
    end

    // streaming with one-cycle read lag across two pointer wraps
    for (int k = 0; k <= 20; k++) begin
      drive(1, (k < 20), (k > 0), tok(k));
      if (k > 0) begin
        chk($sformatf("stream_out%0d", k), 32'(out_a), 32'(tok(k - 1)));
        chk($sformatf("stream_valid%0d", k), 32'(valid_a), 32'd1);
      end
      chk($sformatf("stream_cnt%0d", k), 32'(cnt_a), (k < 20) ? 32'd1 : 32'd0);
    end
    chk("stream_flags", {30'd0, ovf_a, udf_a}, 32'd0);

    // half-fill then reset mid-burst
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 16'(16'hD000 + i));
    end
    chk("half_cnt", 32'(cnt_a), 32'd4);
    drive(0, 1, 0, 16'hDEAD);
    chk("midrst_a", pack_a(), {7'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("midrst_b_cnt", 32'(cnt_b), 32'd2);
    chk("midrst_c_full", {30'd0, full_c, empty_c}, 32'd2);

    // preloaded zeros come out ahead of the written token
    drive(1, 1, 0, 16'hAAAA);
    chk("pre_b_cnt", 32'(cnt_b), 32'd3);
    chk("pre_c_ovf", 32'(ovf_c), 32'd1);
    drive(1, 0, 1, 16'h0000);
    chk("pre_b_rd0", {15'd0, out_b, valid_b}, {15'd0, 16'h0000, 1'b1});
    chk("pre_a_rd0", {15'd0, out_a, valid_a}, {15'd0, 16'hAAAA, 1'b1});
    chk("pre_c_rd0", {15'd0, out_c, valid_c}, {15'd0, 16'h0000, 1'b1});
    drive(1, 0, 1, 16'h0000);
    chk("pre_b_rd1", {15'd0, out_b, valid_b}, {15'd0, 16'h0000, 1'b1});
    chk("pre_a_udf", {14'd0, out_a, valid_a, udf_a}, {14'd0, 16'hAAAA, 1'b0, 1'b1});
    drive(1, 0, 1, 16'h0000);
    chk("pre_b_rd2", {15'd0, out_b, valid_b}, {15'd0, 16'hAAAA, 1'b1});
    chk("pre_b_end", {28'd0, cnt_b}, 32'd0);
    drive(1, 0, 0, 16'h0000);
    chk("pre_b_idle", {15'd0, out_b, valid_b}, {15'd0, 16'hAAAA, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kpn_fifo_channel.md
Name: kpn_fifo_channel

Overview:
- Bounded FIFO channel that connects two KPN processes.
- Acts as the responder to the rd/wr strobes driven by KPN process modules such as delay, adder and splitter. The producer side writes 16-bit tokens; the consumer side reads them in order.
- Supports preloading initial zero tokens at reset, which gives the network-level delay semantics inside the channel itself.
- Sits between every producer/consumer pair in the generated KPN top level.

Parameters:
- DATA_WIDTH, 16, token width in bits.
- DEPTH, 8, number of token slots. Must be a power of 2, at least 2.
- INIT_TOKENS, 0, number of zero tokens present after reset. Range 0..DEPTH.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- wr  input  1  producer write strobe; one token per cycle while high.
- entry_1  input  DATA_WIDTH  producer token, sampled when wr is accepted.
- rd  input  1  consumer read strobe; one token per cycle while high.
- output_1  output  DATA_WIDTH  last token read, registered.
- valid_out  output  1  one-cycle pulse when output_1 was updated by an accepted read.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  tokens currently stored.
- overflow  output  1  sticky; a write was rejected.
- underflow  output  1  sticky; a read was rejected.

Behaviour:
- Reset (rst_n low at posedge):
  - wr_ptr = INIT_TOKENS mod DEPTH, rd_ptr = 0, count = INIT_TOKENS.
  - Slots 0..INIT_TOKENS-1 cleared to 0.
  - output_1 = 0, valid_out = 0, overflow = 0, underflow = 0.
  - full = (INIT_TOKENS == DEPTH), empty = (INIT_TOKENS == 0).
  - Reset during any traffic discards all stored tokens. In-flight strobes in the reset cycle are ignored.
- Accept rules, evaluated on current-cycle state:
  - wr_acc = wr & (~full | rd_acc).
  - rd_acc = rd & ~empty.
- Write path: on wr_acc, mem[wr_ptr] <= entry_1 and wr_ptr increments, wrapping at DEPTH.
- Read path:
  - On rd_acc, output_1 <= mem[rd_ptr], rd_ptr increments with wrap, and valid_out = 1 next cycle. Read latency is 1 cycle from the rd edge.
  - No rd_acc: output_1 holds its value and valid_out = 0.
- Count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Simultaneous rd & wr:
  - When full: both accepted, count stays DEPTH, no overflow.
  - When empty: write accepted, read rejected (no bypass), underflow set, count becomes 1.
  - Otherwise: both accepted, count unchanged.
- Errors:
  - wr & ~wr_acc leaves memory and pointers untouched and sets overflow.
  - rd & empty sets underflow.
  - Both flags stay set until reset.
- Pointers are log2(DEPTH) bits and wrap naturally. full and empty are derived from count, not from pointer compare.
- Token order is strict FIFO. Preloaded zeros are read before any written token.
- Internal channel state: EMPTY / PARTIAL / FULL, derived from count.
  - EMPTY->PARTIAL on wr_acc.
  - PARTIAL->FULL when count reaches DEPTH.
  - FULL->PARTIAL on a lone rd_acc.
  - PARTIAL->EMPTY when count reaches 0.

Decomposition:
- Package kpn_pkg:
  - TOKEN_WIDTH = 16.
  - Token type (logic [TOKEN_WIDTH-1:0]).
  - Channel-state enum (EMPTY, PARTIAL, FULL).
  - Shared by all KPN process modules.
- Sub-module kpn_fifo_mem:
  - DEPTH x DATA_WIDTH register array with one write port and one registered read port.
  - Synchronous clear of the first INIT_TOKENS slots on reset.
- kpn_fifo_channel holds the pointers, count, accept logic and flags.

Test Plan:
- INIT_TOKENS=0, DEPTH=8. Write 0x0001..0x0003, then read 3 times -> output_1 = 0x0001, 0x0002, 0x0003 one cycle after each rd, valid_out pulses each time, empty=1 at end, no flags.
- INIT_TOKENS=2. Write 0xAAAA, then read 3 times -> outputs 0x0000, 0x0000, 0xAAAA, which confirms the preloaded delay tokens.
- Fill 8 tokens -> full=1. Write a 9th -> overflow=1 and count=8. Then assert rd & wr together with 0x5555 -> count stays 8. Drain -> 0x5555 arrives last, after the original 8.
- Empty FIFO, rd alone -> underflow=1, output_1 holds previous value, valid_out=0. Then rd & wr 0x1234 together -> count=1. Next rd -> 0x1234.
- Write 20 tokens, reading continuously with 1 cycle lag -> all values in order, which exercises pointer wrap twice; count never exceeds 2.
- Half-fill to 4 tokens, pull rst_n low for 1 cycle mid-burst -> count = INIT_TOKENS, flags clear, output_1 = 0, and old tokens are never read.
